rr_arbiter: RTL
===============

# rr_arbiter

Registered round-robin arbiter that shares one resource, such as a downstream encoder or datapath stage, among `REQ_WIDTH` requesters. A grant is held until the owner signals completion. The next owner is selected by rotating priority, so every active requester is served within `REQ_WIDTH` grants. The block sits between requesting agents and the shared resource, and its `gnt_id` directly addresses that resource.

## Interface
Parameters:
- `REQ_WIDTH`, default 8: number of requesters, at least 2.
- `ID_WIDTH`, default `$clog2(REQ_WIDTH)`: width of the grant index.
- `HOLD_MAX`, default 16: maximum grant length in cycles. Used only when `RR_ARB_TIMEOUT_EN` is defined; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  `REQ_WIDTH`  request vector; bit i set means requester i wants the resource.
- `done`  in  1  current owner releases the grant; ignored while no grant is active.
- `gnt`  out  `REQ_WIDTH`  one-hot grant vector, or all zeros.
- `gnt_id`  out  `ID_WIDTH`  index of the owner; 0 while `gnt_vld`=0.
- `gnt_vld`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse on a forced release; constant 0 without the macro.

## Operation
- Two states:
  - IDLE: no owner.
  - BUSY: exactly one `gnt` bit set, `gnt_vld`=1.
- Priority pointer `ptr` holds the last winner.
  - Search order is `ptr+1`, `ptr+2`, …, `ptr`, modulo `REQ_WIDTH`; the first set `req` bit wins.
  - `ptr` resets to `REQ_WIDTH-1`, so index 0 has top priority after reset.
  - `ptr` loads the winner index on every new grant.
- IDLE → BUSY: at a rising edge where `req` != 0.
- BUSY → BUSY (same owner): while `done`=0. `req` is ignored for the owner and others, so a dropped `req` does not revoke the grant.
- BUSY with `done`=1 at an edge:
  - The grant is released.
  - Arbitration runs on `req` at that same edge.
  - A winner gets a zero-bubble handoff; the old owner is naturally last in order.
  - With no winner, the block goes to IDLE.
- `gnt`, `gnt_id` and `gnt_vld` are all registered and mutually consistent every cycle.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `timeout`=0, state IDLE, `ptr`=`REQ_WIDTH-1`, hold counter 0.
- Grant latency: `req` sampled at edge k gives `gnt` valid in cycle k+1, one cycle.
- Release: `done`=1 sampled at edge k gives the old `gnt` low from cycle k+1. In the same cycle the new `gnt` is high if any `req` bit was set at edge k.
- A single requester holding `req` and pulsing `done` every cycle is re-granted every cycle with no gap.
- Requests that arrive and leave within BUSY without being sampled at an arbitration edge are lost; requesters hold `req` until granted.
- Asynchronous reset in any state forces all reset values immediately, and a grant in flight is dropped. After reset is released, the first arbitration edge obeys normal latency.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - The hold counter increments on each BUSY cycle and clears on every new grant.
  - If `done`=0 at the edge that ends the `HOLD_MAX`-th consecutive cycle of one grant, the release is forced exactly as if `done`=1 were sampled, including handoff.
  - `timeout`=1 for the cycle after that edge.
  - `done`=1 on that same edge is a normal release, with `timeout`=0.
- `RR_ARB_TIMEOUT_EN` undefined:
  - No counter logic is built and `timeout` is tied to 0.
  - Grants last indefinitely until `done`.

## Test plan
- Reset: assert `rst` mid-cycle with `req`=8'hFF → `gnt`=0, `gnt_vld`=0, `gnt_id`=0 without a clock edge. Release reset → `gnt`=8'h01 one cycle after the first edge.
- Fairness: `req`=8'hFF held, `done` pulsed once per grant → `gnt_id` sequence 0,1,2,3,4,5,6,7,0.
- Wrap and skip: after owner 0 releases with `req`=8'h81 → next `gnt_id`=7, then 0, then 7.
- Hold: owner 3 (`gnt`=8'h08), `req` dropped to 0, `done`=0 for 10 cycles → `gnt` stays 8'h08 and `gnt_vld`=1 throughout. With `done`=1 and `req`=0 → IDLE next cycle and `gnt`=0.
- Handoff: owner 2, `req`=8'h24, `done`=1 at edge k → `gnt`=8'h20 in cycle k+1 with no idle cycle.
- Timeout (macro defined, `HOLD_MAX`=4): grant id 2 with `req`=8'h0C and no `done` → after 4 grant cycles, `timeout`=1 for one cycle and `gnt_id`=3 in that same cycle. Without the macro, the same stimulus keeps id 2 and `timeout`=0.

Source files
------------

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter: one grant held until done, rotating priority from the last winner.
// Optional forced release after HOLD_MAX busy cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter #(
    parameter int REQ_WIDTH = 8,
    parameter int ID_WIDTH  = $clog2(REQ_WIDTH),
    parameter int HOLD_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_WIDTH-1:0] req,
    input  logic                 done,
    output logic [REQ_WIDTH-1:0] gnt,
    output logic [ID_WIDTH-1:0]  gnt_id,
    output logic                 gnt_vld,
    output logic                 timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]          state;
    logic [ID_WIDTH-1:0] ptr;
    logic                win_found;
    logic [ID_WIDTH-1:0] win_id;
    logic [ID_WIDTH-1:0] idx;
    logic                force_rel;
    logic                release_now;
    logic                arb;

    // Search ptr+1 .. ptr (wrapping); the last winner is naturally checked last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 1; i <= REQ_WIDTH; i++) begin
            idx = ID_WIDTH'((int'(ptr) + i) % REQ_WIDTH);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign release_now = (state == BUSY) && (done || force_rel);
    assign arb         = (state == IDLE) || release_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= ID_WIDTH'(REQ_WIDTH - 1);
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
        end else if (arb) begin
            if (win_found) begin
                state   <= BUSY;
                ptr     <= win_id;
                gnt     <= REQ_WIDTH'(1) << win_id;
                gnt_id  <= win_id;
                gnt_vld <= 1'b1;
            end else begin
                state   <= IDLE;
                gnt     <= '0;
                gnt_id  <= '0;
                gnt_vld <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    // hold_cnt equals (busy cycles so far - 1); a done on the limit edge wins over the force.
    assign force_rel = (hold_cnt == CNT_W'(HOLD_MAX - 1)) && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == BUSY) && force_rel;
            if (arb) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule
